// File: rtl/sprite_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sprite_pkg : shared constants and types for the sprite attribute table
// Revision   : 1.0
// ============================================================================
package sprite_pkg;

    localparam int NSPR     = 32;
    localparam int SP_H     = 16;
    localparam int MAX_HITS = 8;
    localparam int SPX_W    = 10;
    localparam int SPY_W    = 9;
    localparam int SEL_W    = 5;
    localparam int ROW_W    = 4;

    typedef struct packed {
        logic [SPX_W-1:0] x;
        logic [SPY_W-1:0] y;
        logic             vis;
    } entry_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SPX_W-1:0] x;
        logic [ROW_W-1:0] row;
    } hit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int HIT_W = $bits(hit_t);

endpackage
`default_nettype wire

// File: rtl/sprite_table_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sprite_table_if : CPU sprite-write, line-request and hit-stream signals
// Revision        : 1.0
// ============================================================================
interface sprite_table_if;
    import sprite_pkg::*;

    logic [SEL_W-1:0] spsel;
    logic [SPX_W-1:0] spx;
    logic [SPY_W-1:0] spy;
    logic             sppos;
    logic             spattr;
    logic             spvis;
    logic             line_start;
    logic [SPY_W-1:0] line_y;
    logic             scan_busy;
    logic             scan_done;
    logic             overflow;
    logic             hit_valid;
    logic             hit_ready;
    logic [SEL_W-1:0] hit_sel;
    logic [SPX_W-1:0] hit_x;
    logic [ROW_W-1:0] hit_row;

    modport master (
        output spsel, spx, spy, sppos, spattr, spvis, line_start, line_y, hit_ready,
        input  scan_busy, scan_done, overflow, hit_valid, hit_sel, hit_x, hit_row
    );

    modport slave (
        input  spsel, spx, spy, sppos, spattr, spvis, line_start, line_y, hit_ready,
        output scan_busy, scan_done, overflow, hit_valid, hit_sel, hit_x, hit_row
    );

endinterface
`default_nettype wire

// File: rtl/sprite_hit_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sprite_hit_fifo : synchronous FIFO with flush; head reads as zero when empty
// Revision        : 1.0
// ============================================================================
module sprite_hit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sprite_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sprite_table : CPU-written sprite attribute table with per-line hit scanner
// Revision     : 1.0
// ============================================================================
module sprite_table
    import sprite_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sprite_table_if.slave  bus
);
    localparam int         CNT_W   = $clog2(MAX_HITS + 1);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SCAN = SCAN;

    entry_t           table_q [NSPR];
    entry_t           cur;
    logic [0:0]       state;
    logic [SEL_W-1:0] idx;
    logic [SPY_W-1:0] line_q;
    logic [CNT_W-1:0] hit_cnt;
    logic             done;
    logic             ovf;
    logic [SPY_W:0]   diff;
    logic             hit;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    hit_t             push_hit;
    hit_t             head;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSPR; i++) table_q[i] <= '0;
        end else begin
            if (bus.sppos) begin
                table_q[bus.spsel].x <= bus.spx;
                table_q[bus.spsel].y <= bus.spy;
            end
            if (bus.spattr) table_q[bus.spsel].vis <= bus.spvis;
        end
    end

    // Unsigned 10-bit difference: line above the sprite wraps high and misses.
    assign cur  = table_q[idx];
    assign diff = {1'b0, line_q} - {1'b0, cur.y};
    assign hit  = cur.vis && (diff < (SPY_W+1)'(SP_H));

    assign push_hit.sel = idx;
    assign push_hit.x   = cur.x;
    assign push_hit.row = diff[ROW_W-1:0];

    assign push = (state == ST_SCAN) && !bus.line_start && hit
                  && (hit_cnt != CNT_W'(MAX_HITS)) && !full;
    assign pop  = !empty && bus.hit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            line_q  <= '0;
            hit_cnt <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.line_start) begin
                state   <= ST_SCAN;
                idx     <= '0;
                line_q  <= bus.line_y;
                hit_cnt <= '0;
                ovf     <= 1'b0;
            end else if (state == ST_SCAN) begin
                if (hit) begin
                    if (hit_cnt == CNT_W'(MAX_HITS)) ovf <= 1'b1;
                    else                            hit_cnt <= hit_cnt + 1'b1;
                end
                idx <= idx + 1'b1;
                if (idx == SEL_W'(NSPR - 1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    sprite_hit_fifo #(
        .DEPTH (MAX_HITS),
        .WIDTH (HIT_W)
    ) u_hit_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.line_start),
        .push      (push),
        .push_data (push_hit),
        .pop       (pop),
        .pop_data  (head),
        .empty     (empty),
        .full      (full)
    );

    assign bus.scan_busy = (state == ST_SCAN);
    assign bus.scan_done = done;
    assign bus.overflow  = ovf;
    assign bus.hit_valid = !empty;
    assign bus.hit_sel   = head.sel;
    assign bus.hit_x     = head.x;
    assign bus.hit_row   = head.row;

endmodule
`default_nettype wire

// File: tb/tb_sprite_table.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sprite_table : scoreboard bench with a line-level reference sprite model
// Revision        : 1.0
// ============================================================================
module tb_sprite_table;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sprite_table_if bus();

    sprite_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   tx [NSPR];
    int   ty [NSPR];
    bit   tv [NSPR];
    hit_t pend_q [$];
    hit_t exp_q  [$];
    bit   pend_ovf, exp_ovf, done_pend, started;
    int   start_cyc;
    bit   ready_rand = 1'b0;
    logic ready_fix  = 1'b1;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: loads the expected hit list on line_start, compares every visible head.
    initial begin
        done_pend = 1'b0;
        started   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                done_pend = 1'b0;
                started   = 1'b0;
            end else if (bus.line_start) begin
                exp_q     = pend_q;
                exp_ovf   = pend_ovf;
                done_pend = 1'b1;
                started   = 1'b1;
                start_cyc = cyc;
            end else begin
                if (started) begin
                    check("busy_after_start", int'(bus.scan_busy), 1);
                    check("overflow_cleared", int'(bus.overflow), 0);
                    started = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_valid", int'(bus.hit_valid), 0);
                end else if (bus.hit_valid) begin
                    check("hit_sel", int'(bus.hit_sel), int'(exp_q[0].sel));
                    check("hit_x",   int'(bus.hit_x),   int'(exp_q[0].x));
                    check("hit_row", int'(bus.hit_row), int'(exp_q[0].row));
                    if (bus.hit_ready) void'(exp_q.pop_front());
                end
                if (!done_pend) begin
                    check("spurious_done", int'(bus.scan_done), 0);
                end else if (bus.scan_done) begin
                    check("done_latency", cyc - start_cyc, 33);
                    check("overflow_at_done", int'(bus.overflow), int'(exp_ovf));
                    check("busy_at_done", int'(bus.scan_busy), 0);
                    done_pend = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.hit_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSPR; i++) begin
            tx[i] = 0;
            ty[i] = 0;
            tv[i] = 1'b0;
        end
    endtask

    function automatic void build(int ly);
        int   n;
        hit_t h;
        n = 0;
        pend_q.delete();
        for (int i = 0; i < NSPR; i++) begin
            if (tv[i] && ly >= ty[i] && (ly - ty[i]) < SP_H) begin
                n++;
                if (n <= MAX_HITS) begin
                    h.sel = SEL_W'(i);
                    h.x   = SPX_W'(tx[i]);
                    h.row = ROW_W'(ly - ty[i]);
                    pend_q.push_back(h);
                end
            end
        end
        pend_ovf = (n > MAX_HITS);
    endfunction

    task automatic write(int sel, bit do_pos, int x, int y, bit do_vis, bit v);
        bus.spsel  = SEL_W'(sel);
        bus.sppos  = do_pos;
        bus.spx    = SPX_W'(x);
        bus.spy    = SPY_W'(y);
        bus.spattr = do_vis;
        bus.spvis  = v;
        if (do_pos) begin
            tx[sel] = x;
            ty[sel] = y;
        end
        if (do_vis) tv[sel] = v;
        tick();
        bus.sppos  = 1'b0;
        bus.spattr = 1'b0;
    endtask

    task automatic start_line(int ly);
        tick();
        build(ly);
        bus.line_y     = SPY_W'(ly);
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.scan_done && k < 60) begin
            tick();
            k++;
        end
        check("scan_done_seen", int'(bus.scan_done), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.hit_valid); k++) tick();
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic run_line(int ly);
        start_line(ly);
        wait_done();
        drain();
    endtask

    initial begin
        bus.spsel = '0; bus.spx = '0; bus.spy = '0;
        bus.sppos = 1'b0; bus.spattr = 1'b0; bus.spvis = 1'b0;
        bus.line_start = 1'b0; bus.line_y = '0; bus.hit_ready = 1'b1;
        model_reset();

        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy",     int'(bus.scan_busy), 0);
        check("rst_done",     int'(bus.scan_done), 0);
        check("rst_overflow", int'(bus.overflow),  0);
        check("rst_valid",    int'(bus.hit_valid), 0);
        check("rst_sel",      int'(bus.hit_sel),   0);
        check("rst_x",        int'(bus.hit_x),     0);
        check("rst_row",      int'(bus.hit_row),   0);

        // single hit
        write(3, 1, 100, 40, 1, 1);
        run_line(45);

        // vertical boundaries and no wrap
        write(0, 1, 10, 40, 1, 1);
        run_line(39);
        run_line(40);
        run_line(55);
        run_line(56);
        write(5, 1, 0, 500, 1, 1);
        run_line(5);

        // hit limit
        for (int i = 0; i < 10; i++) write(i, 1, i * 20, 0, 1, 1);
        run_line(0);

        // backpressure: three hits held, then drained back to back
        for (int i = 0; i < 3; i++) write(i, 1, 50 + i, 300, 0, 0);
        ready_fix = 1'b0;
        start_line(305);
        wait_done();
        repeat (8) tick();
        check("bp_valid_held", int'(bus.hit_valid), 1);
        ready_fix = 1'b1;
        tick(); check("bp_drain0", int'(bus.hit_valid), 1);
        tick(); check("bp_drain1", int'(bus.hit_valid), 1);
        tick(); check("bp_drain2", int'(bus.hit_valid), 1);
        tick(); check("bp_empty",  int'(bus.hit_valid), 0);
        drain();

        // visibility cleared
        write(2, 0, 0, 0, 1, 0);
        run_line(305);

        // write to the entry under examination lands after this scan
        write(20, 1, 77, 100, 1, 1);
        start_line(105);
        repeat (20) tick();
        bus.spsel = 5'd20; bus.spx = 10'd300; bus.spy = 9'd200; bus.sppos = 1'b1;
        tx[20] = 300;
        ty[20] = 200;
        tick();
        bus.sppos = 1'b0;
        wait_done();
        drain();
        run_line(105);
        run_line(205);

        // restart mid-scan
        start_line(305);
        repeat (8) tick();
        start_line(0);
        wait_done();
        drain();

        // reset mid-scan
        start_line(0);
        repeat (9) tick();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        check("midrst_busy",  int'(bus.scan_busy), 0);
        check("midrst_valid", int'(bus.hit_valid), 0);
        repeat (40) tick();
        run_line(0);

        // randomized lines with random consumer stalls
        ready_rand = 1'b1;
        for (int n = 0; n < 12; n++) begin
            for (int w = 0; w < 12; w++) begin
                write(int'($urandom_range(0, NSPR - 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 80)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            run_line(int'($urandom_range(0, 95)));
        end
        ready_rand = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
